// File: rtl/mem_port_if.sv
// Memory-port arbitration bus: fetch and data request/ack channels plus the shared memory port.
// The wp_err signal exists only when VECTOR_WP_EN is defined.
interface mem_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
`ifdef VECTOR_WP_EN
  logic              wp_err;
`endif

  // Arbiter side: accepts requests and memory read data, drives acks and the memory port.
  modport master (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
`ifdef VECTOR_WP_EN
    , output wp_err
`endif
  );

  modport slave (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
`ifdef VECTOR_WP_EN
    , input wp_err
`endif
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between fetch and data paths: data-over-fetch priority
// with a fetch starvation guard. Define VECTOR_WP_EN to block data writes to addresses 0 and 1.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 3
) (
  input logic       clk,
  input logic       reset,
  mem_port_if.master bus
);
  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SW     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              gnt_f_q, gnt_f_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              take_f;
  logic              wp_hit;
`ifdef VECTOR_WP_EN
  logic              blk_q, blk_d;
  logic              wp_err_q, wp_err_d;

  // Reset and interrupt vectors live at addresses 0 and 1.
  assign wp_hit = bus.d_we && (bus.d_addr[ADDR_W-1:1] == '0);
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    starve_d    = starve_q;
    gnt_f_d     = gnt_f_q;
    we_d        = we_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    take_f      = 1'b0;
`ifdef VECTOR_WP_EN
    blk_d       = blk_q;
    wp_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          take_f   = bus.f_req && (!bus.d_req || (starve_q == STARVE_TOP));
          state_d  = S_ACCESS;
          wcnt_d   = '0;
          mem_en_d = 1'b1;
          gnt_f_d  = take_f;
          if (take_f) begin
            mem_addr_d  = bus.f_addr;
            mem_wdata_d = '0;
            we_d        = 1'b0;
            mem_we_d    = 1'b0;
            starve_d    = '0;
`ifdef VECTOR_WP_EN
            blk_d       = 1'b0;
`endif
          end else begin
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            we_d        = bus.d_we;
            mem_we_d    = bus.d_we && !wp_hit;
            if (bus.f_req && (starve_q != STARVE_TOP)) starve_d = starve_q + 1'b1;
`ifdef VECTOR_WP_EN
            blk_d       = wp_hit;
`endif
          end
        end
      end
      S_ACCESS: begin
        if (wcnt_q == WCNT_LAST) begin
          // Memory read data is taken at the end of the last enable cycle.
          state_d  = S_ACK;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_f_q) begin
            f_ack_d   = 1'b1;
            f_rdata_d = bus.mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = bus.mem_rdata;
`ifdef VECTOR_WP_EN
            wp_err_d = blk_q;
`endif
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      starve_q    <= '0;
      gnt_f_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef VECTOR_WP_EN
      blk_q       <= 1'b0;
      wp_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      gnt_f_q     <= gnt_f_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_ack_q     <= f_ack_d;
      d_ack_q     <= d_ack_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef VECTOR_WP_EN
      blk_q       <= blk_d;
      wp_err_q    <= wp_err_d;
`endif
    end
  end

  assign bus.f_ack     = f_ack_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
`ifdef VECTOR_WP_EN
  assign bus.wp_err    = wp_err_q;
`endif
endmodule
